move_queue: RTL and testbench

- Parametrised successor to the fixed 50-move sequencer.
- Accepts batches of packed 4-bit cube moves from the solver or the state-scan path, and buffers them in a circular queue of DEPTH entries.
- Removes adjacent move/inverse pairs as they are enqueued.
- Dispatches moves one at a time to the stepper driver over a start/done handshake, gated by a run enable.

---
 rtl/move_defs_pkg.sv | 29 ++
 rtl/move_ring_buffer.sv | 48 ++++
 rtl/move_queue.sv | 111 +++++++++++
 tb/tb_move_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/move_defs_pkg.sv
// move_defs: shared cube-move codes, colour codes, FSM state types and move helpers
// Codes 2..13 are valid moves; 0, 1, 14 and 15 terminate a batch.
// A move and its inverse differ only in bit 0.
package move_defs;
    localparam logic [3:0] R  = 4'd2;
    localparam logic [3:0] RI = 4'd3;
    localparam logic [3:0] U  = 4'd4;
    localparam logic [3:0] UI = 4'd5;
    localparam logic [3:0] F  = 4'd6;
    localparam logic [3:0] FI = 4'd7;
    localparam logic [3:0] L  = 4'd8;
    localparam logic [3:0] LI = 4'd9;
    localparam logic [3:0] B  = 4'd10;
    localparam logic [3:0] BI = 4'd11;
    localparam logic [3:0] D  = 4'd12;
    localparam logic [3:0] DI = 4'd13;

    typedef enum logic [2:0] {C_WHITE, C_YELLOW, C_RED, C_ORANGE, C_GREEN, C_BLUE} color_t;
    typedef enum logic {L_IDLE, L_PUSH} load_state_t;
    typedef enum logic {D_IDLE, D_WAIT} disp_state_t;

    function automatic logic is_move(input logic [3:0] m);
        return m >= R && m <= DI;
    endfunction

    function automatic logic [3:0] inverse(input logic [3:0] m);
        return m ^ 4'd1;
    endfunction
endpackage

// File: rtl/move_ring_buffer.sv
// move_ring_buffer: DEPTH x 4-bit circular queue with head pop and tail pop
// Ports: clock_25mhz/reset (sync, active-high); clear empties the queue;
// push writes push_data at the tail; pop_head drops the oldest entry;
// pop_tail drops the newest entry; head_data/tail_data show the oldest/newest
// entries; count is the occupancy. The caller never pushes and tail-pops
// together, and never pushes when full.
module move_ring_buffer #(
    parameter int DEPTH = 64
) (
    input  logic                     clock_25mhz,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [3:0]               push_data,
    input  logic                     pop_head,
    input  logic                     pop_tail,
    output logic [3:0]               head_data,
    output logic [3:0]               tail_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] tail_prev;

    assign tail_prev = tail - 1'b1;
    assign head_data = mem[head];
    assign tail_data = mem[tail_prev];

    always_ff @(posedge clock_25mhz) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= push ? tail + 1'b1 : pop_tail ? tail_prev : tail;
            head  <= pop_head ? head + 1'b1 : head;
            count <= count + CW'(push) - CW'(pop_head) - CW'(pop_tail);
        end
    end

    always_ff @(posedge clock_25mhz) begin
        if (push) mem[tail] <= push_data;
    end
endmodule

// File: rtl/move_queue.sv
// move_queue: buffers batches of cube moves, cancels move/inverse pairs, dispatches to the stepper
// Ports: clock_25mhz/reset (sync, active-high); load latches batch (slot 0 first);
// flush empties the queue and aborts loading; run enables dispatch;
// next_move/move_start present a move to the stepper, move_done ends it;
// load_busy, count, empty, full, overflow (sticky), dispatched and idle report status.
module move_queue
    import move_defs::*;
#(
    parameter int BATCH     = 50,
    parameter int DEPTH     = 64,
    parameter bit CANCEL_EN = 1'b1
) (
    input  logic                     clock_25mhz,
    input  logic                     reset,
    input  logic                     load,
    input  logic [BATCH*4-1:0]       batch,
    input  logic                     flush,
    input  logic                     run,
    output logic [3:0]               next_move,
    output logic                     move_start,
    input  logic                     move_done,
    output logic                     load_busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic [15:0]              dispatched,
    output logic                     idle
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(BATCH + 1);

    load_state_t        l_state, l_next;
    disp_state_t        d_state, d_next;
    logic [BATCH*4-1:0] slots;
    logic [IW-1:0]      idx;
    logic [3:0]         m;
    logic [3:0]         head_data;
    logic [3:0]         tail_data;
    logic               slot_valid;
    logic               pop;
    logic               cancel;
    logic               push;
    logic               drop;

    // The latched batch shifts down one slot per cycle, so the current slot is always bits [3:0].
    assign m          = slots[3:0];
    assign slot_valid = l_state == L_PUSH && is_move(m) && !flush;
    assign pop        = d_state == D_IDLE && run && count != '0 && !flush;
    // With one entry the head is the tail, so a same-cycle pop removes the entry we would cancel against.
    assign cancel     = CANCEL_EN && slot_valid && count != '0 && tail_data == inverse(m) && !(pop && count == CW'(1));
    assign push       = slot_valid && !cancel && count != CW'(DEPTH);
    assign drop       = slot_valid && !cancel && count == CW'(DEPTH);

    assign load_busy  = l_state == L_PUSH;
    assign empty      = count == '0;
    assign full       = count == CW'(DEPTH);
    assign idle       = empty && !load_busy && d_state == D_IDLE;

    move_ring_buffer #(.DEPTH(DEPTH)) u_ring (
        .clock_25mhz (clock_25mhz),
        .reset       (reset),
        .clear       (flush),
        .push        (push),
        .push_data   (m),
        .pop_head    (pop),
        .pop_tail    (cancel),
        .head_data   (head_data),
        .tail_data   (tail_data),
        .count       (count)
    );

    always_comb begin
        l_next = l_state;
        d_next = d_state;
        if (flush) l_next = L_IDLE;
        else if (l_state == L_IDLE) l_next = load ? L_PUSH : L_IDLE;
        else l_next = (!is_move(m) || idx == IW'(BATCH - 1)) ? L_IDLE : L_PUSH;
        if (d_state == D_IDLE) d_next = pop ? D_WAIT : D_IDLE;
        else d_next = move_done ? D_IDLE : D_WAIT;
    end

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            l_state    <= L_IDLE;
            d_state    <= D_IDLE;
            slots      <= '0;
            idx        <= '0;
            next_move  <= '0;
            move_start <= 1'b0;
            overflow   <= 1'b0;
            dispatched <= '0;
        end else begin
            l_state    <= l_next;
            d_state    <= d_next;
            move_start <= pop;
            overflow   <= flush ? 1'b0 : overflow | drop;
            if (pop) begin
                next_move  <= head_data;
                dispatched <= dispatched + 16'd1;
            end
            if (l_state == L_IDLE && load) begin
                slots <= batch;
                idx   <= '0;
            end else if (l_state == L_PUSH) begin
                slots <= slots >> 4;
                idx   <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_move_queue.sv
// tb_move_queue: directed self-checking bench for move_queue (default, no-cancel and DEPTH=4 instances)
module tb_move_queue;
    import move_defs::*;

    logic         clock_25mhz = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic         flush = 1'b0;
    logic         run = 1'b0;
    logic         move_done = 1'b0;
    logic [199:0] batch = '0;

    logic [3:0]  m_next, n_next, q_next;
    logic        m_start, n_start, q_start;
    logic        m_busy, n_busy, q_busy;
    logic [6:0]  m_count, n_count;
    logic [2:0]  q_count;
    logic        m_empty, n_empty, q_empty;
    logic        m_full, n_full, q_full;
    logic        m_ovf, n_ovf, q_ovf;
    logic [15:0] m_disp, n_disp, q_disp;
    logic        m_idle, n_idle, q_idle;

    int checks = 0;
    int errors = 0;

    always #20 clock_25mhz = ~clock_25mhz;

    move_queue u_main (
        .clock_25mhz(clock_25mhz), .reset(reset), .load(load), .batch(batch), .flush(flush),
        .run(run), .next_move(m_next), .move_start(m_start), .move_done(move_done),
        .load_busy(m_busy), .count(m_count), .empty(m_empty), .full(m_full),
        .overflow(m_ovf), .dispatched(m_disp), .idle(m_idle)
    );

    move_queue #(.CANCEL_EN(1'b0)) u_nc (
        .clock_25mhz(clock_25mhz), .reset(reset), .load(load), .batch(batch), .flush(flush),
        .run(run), .next_move(n_next), .move_start(n_start), .move_done(move_done),
        .load_busy(n_busy), .count(n_count), .empty(n_empty), .full(n_full),
        .overflow(n_ovf), .dispatched(n_disp), .idle(n_idle)
    );

    move_queue #(.DEPTH(4)) u_d4 (
        .clock_25mhz(clock_25mhz), .reset(reset), .load(load), .batch(batch), .flush(flush),
        .run(run), .next_move(q_next), .move_start(q_start), .move_done(move_done),
        .load_busy(q_busy), .count(q_count), .empty(q_empty), .full(q_full),
        .overflow(q_ovf), .dispatched(q_disp), .idle(q_idle)
    );

    task automatic step();
        @(negedge clock_25mhz);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load = 1'b0;
        flush = 1'b0;
        run = 1'b0;
        move_done = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_load(input logic [31:0] v);
        batch = {168'b0, v};
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!m_start && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(m_start), 32'd1);
    endtask

    task automatic wait_load(input string tag);
        int n = 0;
        while (m_busy && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(m_busy), 32'd0);
    endtask

    task automatic finish_move();
        repeat (10) step();
        move_done = 1'b1;
        step();
        move_done = 1'b0;
    endtask

    logic [3:0] seq1 [3] = '{R, U, F};
    logic [3:0] seq4 [4] = '{R, U, F, L};
    int n;
    int starts;

    initial begin
        // reset state
        do_reset();
        chk("rst_count", 32'(m_count), 0);
        chk("rst_next", 32'(m_next), 0);
        chk("rst_start", 32'(m_start), 0);
        chk("rst_busy", 32'(m_busy), 0);
        chk("rst_ovf", 32'(m_ovf), 0);
        chk("rst_disp", 32'(m_disp), 0);
        chk("rst_idle", 32'(m_idle), 1);
        chk("rst_empty", 32'(m_empty), 1);

        // basic dispatch of R,U,F
        run = 1'b1;
        pulse_load(32'h0000_0642);
        chk("t1_busy", 32'(m_busy), 1);
        for (int i = 0; i < 3; i++) begin
            wait_start("t1_start");
            chk("t1_next", 32'(m_next), 32'(seq1[i]));
            finish_move();
        end
        repeat (3) step();
        chk("t1_disp", 32'(m_disp), 3);
        chk("t1_idle", 32'(m_idle), 1);
        chk("t1_nostart", 32'(m_start), 0);

        // cancellation: R,U,Ui,Ri,F
        do_reset();
        pulse_load(32'h0006_3542);
        n = 0;
        while (m_busy && n < 100) begin
            step();
            n++;
        end
        chk("t2_busy_len", 32'(n), 6);
        chk("t2_count", 32'(m_count), 1);
        chk("t2_nc_count", 32'(n_count), 5);
        chk("t2_empty", 32'(m_empty), 0);
        run = 1'b1;
        wait_start("t2_start");
        chk("t2_head", 32'(m_next), 32'(F));
        run = 1'b0;
        finish_move();

        // DEPTH=4 overflow, contents, flush
        do_reset();
        pulse_load(32'h00CA_8642);
        wait_load("t3_load");
        chk("t3_q_count", 32'(q_count), 4);
        chk("t3_q_full", 32'(q_full), 1);
        chk("t3_q_ovf", 32'(q_ovf), 1);
        chk("t3_m_count", 32'(m_count), 6);
        chk("t3_m_ovf", 32'(m_ovf), 0);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start("t3_start");
            chk("t3_q_start", 32'(q_start), 1);
            chk("t3_q_next", 32'(q_next), 32'(seq4[i]));
            if (i == 3) run = 1'b0;
            finish_move();
        end
        repeat (3) step();
        chk("t3_q_empty", 32'(q_empty), 1);
        chk("t3_q_ovf_sticky", 32'(q_ovf), 1);
        chk("t3_m_left", 32'(m_count), 2);
        batch = {196'b0, R};
        flush = 1'b1;
        load = 1'b1;
        step();
        flush = 1'b0;
        load = 1'b0;
        chk("t3_flush_count", 32'(m_count), 0);
        chk("t3_flush_busy", 32'(m_busy), 0);
        chk("t3_flush_ovf", 32'(q_ovf), 0);
        chk("t3_flush_qcount", 32'(q_count), 0);

        // run gating with a move in flight
        do_reset();
        run = 1'b1;
        pulse_load(32'h0000_0042);
        wait_start("t4_first");
        chk("t4_first_next", 32'(m_next), 32'(R));
        run = 1'b0;
        repeat (5) step();
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        starts = 0;
        repeat (10) begin
            step();
            if (m_start) starts++;
        end
        chk("t4_blocked", 32'(starts), 0);
        chk("t4_count", 32'(m_count), 1);
        chk("t4_disp", 32'(m_disp), 1);
        run = 1'b1;
        wait_start("t4_second");
        chk("t4_second_next", 32'(m_next), 32'(U));
        chk("t4_disp2", 32'(m_disp), 2);
        run = 1'b0;
        finish_move();

        // push Ri on the cycle R is popped: no cancellation
        do_reset();
        pulse_load(32'h0000_0002);
        wait_load("t5_load");
        chk("t5_count1", 32'(m_count), 1);
        pulse_load(32'h0000_0003);
        run = 1'b1;
        step();
        chk("t5_count", 32'(m_count), 1);
        chk("t5_start", 32'(m_start), 1);
        chk("t5_next", 32'(m_next), 32'(R));
        finish_move();
        wait_start("t5_start2");
        chk("t5_next2", 32'(m_next), 32'(RI));
        run = 1'b0;
        finish_move();

        // reset in D_WAIT with three queued
        do_reset();
        run = 1'b1;
        pulse_load(32'h0000_8642);
        wait_start("t6_start");
        wait_load("t6_load");
        chk("t6_count", 32'(m_count), 3);
        chk("t6_idle", 32'(m_idle), 0);
        reset = 1'b1;
        step();
        chk("t6_count_rst", 32'(m_count), 0);
        chk("t6_start_rst", 32'(m_start), 0);
        chk("t6_busy_rst", 32'(m_busy), 0);
        chk("t6_disp_rst", 32'(m_disp), 0);
        chk("t6_next_rst", 32'(m_next), 0);
        reset = 1'b0;
        run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
